// File: rtl/scan_tx_formatter_pkg.sv
// Shared constants and helpers for the scan byte serializer.
// Contents: tag values, the serializer state type and the byte encoder.
package scan_tx_formatter_pkg;

  localparam int unsigned PAYLOAD_W = 5;
  localparam int unsigned TAG_W     = 3;
  localparam int unsigned BYTE_W    = TAG_W + PAYLOAD_W;

  localparam logic [TAG_W-1:0] TAG_MOVE  = 3'b001;
  localparam logic [TAG_W-1:0] TAG_LEFT  = 3'b010;
  localparam logic [TAG_W-1:0] TAG_RIGHT = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  // Highest-priority request wins: move_done > left > right.
  function automatic logic [BYTE_W-1:0] encode_byte(
    input logic                 move_done,
    input logic                 left,
    input logic [PAYLOAD_W-1:0] pcs
  );
    if (move_done) begin
      return {TAG_MOVE, PAYLOAD_W'(0)};
    end else if (left) begin
      return {TAG_LEFT, pcs};
    end else begin
      return {TAG_RIGHT, pcs};
    end
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Phase-accumulator baud divider producing a one-cycle registered tick.
// Ports: clk, reset (sync, active high), restart (re-phase to a frame
// start), tick (one-cycle pulse per baud period).
module baud_tick_gen #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned ACC_W = 33;
  localparam logic [ACC_W-1:0] INC   = ACC_W'(BAUD);
  localparam logic [ACC_W-1:0] LIMIT = ACC_W'(CLK_FREQ);
  // Preset of 1.5 increments lands the first tick at round(CLK_FREQ/BAUD)
  // cycles after restart, accounting for the registered tick.
  localparam logic [ACC_W-1:0] PRESET = ACC_W'(BAUD) + ACC_W'(BAUD / 2);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_sum;
  logic             tick_q;

  assign acc_sum = acc_q + INC;
  assign tick    = tick_q;

  // Accumulate BAUD per clock; wrap past CLK_FREQ emits a tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else if (restart) begin
      acc_q  <= PRESET;
      tick_q <= 1'b0;
    end else if (acc_sum >= LIMIT) begin
      acc_q  <= acc_sum - LIMIT;
      tick_q <= 1'b1;
    end else begin
      acc_q  <= acc_sum;
      tick_q <= 1'b0;
    end
  end

endmodule

// File: rtl/scan_tx_formatter.sv
// Formats scan/move requests into tagged bytes and sends them 8N1, LSB first.
// Ports: clk, reset (sync, active high); send_move_done/send_left/send_right
// level requests; pieces scan payload; TxD serial line (idle high);
// TxD_busy high from the cycle after capture until the stop bit ends.
module scan_tx_formatter
  import scan_tx_formatter_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 send_move_done,
  input  logic                 send_left,
  input  logic                 send_right,
  input  logic [PAYLOAD_W-1:0] pieces,
  output logic                 TxD,
  output logic                 TxD_busy
);

  tx_state_e         state_q;
  logic [BYTE_W-1:0] shreg_q;
  logic [2:0]        bitcnt_q;
  logic              txd_q;
  logic              busy_q;
  logic              any_req;
  logic              capture;
  logic              baud_tick;

  assign any_req = send_move_done | send_left | send_right;
  // Reset overrides a request on the same edge.
  assign capture = (state_q == ST_IDLE) && any_req && !reset;

  assign TxD      = txd_q;
  assign TxD_busy = busy_q;

  baud_tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .restart (capture),
    .tick    (baud_tick)
  );

  // Frame sequencer: capture, start bit, 8 data bits, stop bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          txd_q <= 1'b1;
          if (any_req) begin
            shreg_q <= encode_byte(send_move_done, send_left, pieces);
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (baud_tick) begin
            txd_q    <= shreg_q[0];
            shreg_q  <= {1'b0, shreg_q[BYTE_W-1:1]};
            bitcnt_q <= '0;
            state_q  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            if (bitcnt_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              txd_q    <= shreg_q[0];
              shreg_q  <= {1'b0, shreg_q[BYTE_W-1:1]};
              bitcnt_q <= bitcnt_q + 3'd1;
            end
          end
        end
        ST_STOP: begin
          if (baud_tick) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_tx_formatter.sv
// Scoreboard bench for scan_tx_formatter: requests push expected bytes,
// a UART monitor decodes frames off TxD and checks bytes and bit timing.
module tb_scan_tx_formatter;

  localparam int unsigned CLK_FREQ = 50000000;
  localparam int unsigned BAUD     = 115200;
  localparam real         BIT_P    = real'(CLK_FREQ) / real'(BAUD);
  localparam int          MAXLEN   = 4400;

  logic       clk = 1'b0;
  logic       reset;
  logic       send_move_done;
  logic       send_left;
  logic       send_right;
  logic [4:0] pieces;
  logic       TxD;
  logic       TxD_busy;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  bit         mon_en = 1'b0;
  bit         abort_pending = 1'b0;

  always #5 clk = ~clk;

  scan_tx_formatter #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .send_move_done (send_move_done),
    .send_left      (send_left),
    .send_right     (send_right),
    .pieces         (pieces),
    .TxD            (TxD),
    .TxD_busy       (TxD_busy)
  );

  function automatic int rnd(input real x);
    return $rtoi(x + 0.5);
  endfunction

  task automatic check_tol(input string name, input int act, input int req, input int tol);
    int d;
    d = act - req;
    tests++;
    if (d > tol || d < -tol) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d) at %0t", name, act, req, tol, $time);
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    check_tol(name, act, req, 0);
  endtask

  task automatic tick_wait();
    @(posedge clk);
    #1;
  endtask

  // Reference encoding: tag in [7:5], payload in [4:0], fixed priority.
  function automatic logic [7:0] model_byte();
    if (send_move_done) return 8'h20;
    if (send_left)      return {3'b010, pieces};
    return {3'b011, pieces};
  endfunction

  task automatic drop_winner();
    if (send_move_done)  send_move_done = 1'b0;
    else if (send_left)  send_left = 1'b0;
    else                 send_right = 1'b0;
  endtask

  task automatic clear_reqs();
    send_move_done = 1'b0;
    send_left      = 1'b0;
    send_right     = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input int limit, output int cyc);
    cyc = 0;
    do begin
      tick_wait();
      cyc++;
    end while (TxD_busy !== lvl && cyc < limit);
    if (TxD_busy !== lvl) begin
      tests++;
      fails++;
      $display("FAIL busy_wait: busy still %b after %0d cycles, expected %b", TxD_busy, cyc, lvl);
      cyc = -1;
    end
  endtask

  // Upstream model: serve requests in priority order until none remain.
  task automatic run_requests(input bit keep_first, input bit change_mid);
    int n;
    int cyc;
    n = 0;
    while ((send_move_done | send_left | send_right) && n < 8) begin
      exp_q.push_back(model_byte());
      wait_busy(1'b1, 4, cyc);
      check("capture_latency", cyc, 1);
      if (cyc < 0) begin
        clear_reqs();
      end else begin
        if (change_mid && n == 0) begin
          repeat (1000) tick_wait();
          pieces = 5'($urandom);
        end
        if (!(keep_first && n == 0)) drop_winner();
        wait_busy(1'b0, MAXLEN, cyc);
        if (cyc < 0) clear_reqs();
      end
      n++;
    end
  endtask

  // Monitor: decode each frame from its start bit and score it.
  initial begin
    logic       lvl [MAXLEN];
    logic [9:0] bits;
    logic [7:0] exp_b;
    logic       prev_busy;
    int         n;
    int         b;
    int         t;
    int         s;
    prev_busy = 1'b0;
    forever begin
      tick_wait();
      if (mon_en && TxD === 1'b0) begin
        check("start_with_busy_rise", int'({prev_busy, TxD_busy}), 1);
        lvl[0] = 1'b0;
        n = 1;
        while (n < MAXLEN && TxD_busy === 1'b1) begin
          tick_wait();
          if (TxD_busy === 1'b1) begin
            lvl[n] = TxD;
            n++;
          end
        end
        if (abort_pending) begin
          abort_pending = 1'b0;
          check("aborted_frame_short", int'(n < rnd(10.0 * BIT_P) - 2), 1);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: frame seen with empty scoreboard at %0t", $time);
        end else begin
          exp_b = exp_q.pop_front();
          for (int j = 0; j < 10; j++) begin
            s = rnd((real'(j) + 0.5) * BIT_P);
            bits[j] = (s < n) ? lvl[s] : 1'b0;
          end
          check("start_bit", int'(bits[0]), 0);
          check("stop_bit", int'(bits[9]), 1);
          check("data_byte", int'(bits[8:1]), int'(exp_b));
          check_tol("busy_len", n, rnd(10.0 * BIT_P), 1);
          for (int j = 1; j < 10; j++) begin
            if (bits[j] != bits[j-1]) begin
              b = rnd(real'(j) * BIT_P);
              t = -1;
              for (int k = b - 3; k <= b + 3; k++) begin
                if (t < 0 && k < n && lvl[k] == bits[j]) t = k;
              end
              check_tol("bit_edge", t, b, 1);
            end
          end
        end
      end
      prev_busy = TxD_busy;
    end
  end

  // Stimulus
  initial begin
    int cyc;
    int cnt;
    reset = 1'b1;
    clear_reqs();
    pieces = '0;
    repeat (3) tick_wait();
    check("reset_txd", int'(TxD), 1);
    check("reset_busy", int'(TxD_busy), 0);
    reset = 1'b0;
    tick_wait();
    check("idle_txd", int'(TxD), 1);
    mon_en = 1'b1;
    repeat (2) tick_wait();

    // Single left scan byte 0x56.
    pieces = 5'b10110;
    send_left = 1'b1;
    run_requests(1'b0, 1'b0);
    repeat (3) tick_wait();

    // All three together: served move, left, right in order.
    pieces = 5'($urandom);
    send_move_done = 1'b1;
    send_left = 1'b1;
    send_right = 1'b1;
    run_requests(1'b0, 1'b0);
    repeat (3) tick_wait();

    // Right held through a frame with pieces changing mid-frame.
    pieces = 5'($urandom);
    send_right = 1'b1;
    run_requests(1'b1, 1'b1);
    repeat (3) tick_wait();

    // Reset on the same edge as a request wins.
    reset = 1'b1;
    send_move_done = 1'b1;
    tick_wait();
    send_move_done = 1'b0;
    reset = 1'b0;
    cnt = 0;
    repeat (5) begin
      tick_wait();
      if (TxD_busy !== 1'b0) cnt++;
    end
    check("reset_override", cnt, 0);

    // Reset during data bit 4 aborts the frame.
    pieces = 5'($urandom);
    send_left = 1'b1;
    abort_pending = 1'b1;
    exp_q.push_back(model_byte());
    wait_busy(1'b1, 4, cyc);
    check("capture_latency", cyc, 1);
    send_left = 1'b0;
    repeat (rnd(5.5 * BIT_P)) tick_wait();
    reset = 1'b1;
    tick_wait();
    check("abort_txd", int'(TxD), 1);
    check("abort_busy", int'(TxD_busy), 0);
    reset = 1'b0;
    cnt = 0;
    repeat (20) begin
      tick_wait();
      if (TxD !== 1'b1) cnt++;
    end
    check("no_partial_retx", cnt, 0);
    pieces = 5'($urandom);
    send_right = 1'b1;
    run_requests(1'b0, 1'b0);
    repeat (3) tick_wait();

    // Random request mixes.
    for (int r = 0; r < 3; r++) begin
      cnt = int'($urandom_range(1, 7));
      pieces = 5'($urandom);
      send_move_done = cnt[2];
      send_left = cnt[1];
      send_right = cnt[0];
      run_requests(1'b0, 1'b0);
      repeat (int'($urandom_range(1, 5))) tick_wait();
    end

    repeat (10) tick_wait();
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
